// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the fetch stage: in-order PC -> word
// replies after a fixed latency, with a backpressure buffer and flush.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/ready/pc    fetch request handshake and byte address
//   resp_valid/ready      head-of-buffer response handshake
//   resp_pc/instr/err     returned PC, word (0 on error), error flag
//   flush                 drop all in-flight and buffered responses
//   ld_en/idx/data        ROM write port for boot/bench loading
module imem_fetch_responder #(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] BASE       = 32'h0000_3000,
  parameter int          LATENCY    = 2,
  parameter int          RESP_DEPTH = 4,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_pc,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_pc,
  output logic [31:0]   resp_instr,
  output logic          resp_err,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_idx,
  input  logic [31:0]   ld_data
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [32:0] LIMIT =
    {1'b0, BASE} + 33'(4 * DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  logic [31:0] rom [DEPTH];

  logic [CW-1:0] outst;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  ent_t          rbuf [RESP_DEPTH];

  logic [LATENCY-1:0] pv;
  ent_t               pe [LATENCY];

  logic    acc;
  logic    fire;
  logic    push;
  logic    bad;
  logic [AW-1:0] idx;
  ent_t    new_ent;
  ent_t    head;

  assign req_ready = !reset && !flush &&
                     (outst < CW'(RESP_DEPTH));
  assign acc  = req_valid && req_ready;
  assign fire = resp_valid && resp_ready;
  assign push = pv[LATENCY-1];

  // Upper bound compared in 33 bits so BASE+4*DEPTH cannot wrap.
  assign bad = (req_pc[1:0] != 2'b00) ||
               (req_pc < BASE) ||
               ({1'b0, req_pc} >= LIMIT);
  assign idx = AW'((req_pc - BASE) >> 2);

  always_comb begin
    new_ent       = '0;
    new_ent.pc    = req_pc;
    new_ent.err   = bad;
    new_ent.instr = bad ? 32'h0 : rom[idx];
  end

  // Nonblocking write: a same-edge fetch still reads the old word.
  always_ff @(posedge clk) begin
    if (ld_en) rom[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pv <= '0;
    end else begin
      pv[0] <= acc;
      for (int k = 1; k < LATENCY; k++)
        pv[k] <= pv[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pe[0] <= new_ent;
    for (int k = 1; k < LATENCY; k++)
      pe[k] <= pe[k-1];
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push)
      rbuf[wp] <= pe[LATENCY-1];
  end

  // outst covers pipe + buffer, so a push can never hit a full buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      outst <= '0;
      cnt   <= '0;
      wp    <= '0;
      rp    <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (fire) rp <= rp + PW'(1);
      case ({acc, fire})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: outst <= outst;
      endcase
      case ({push, fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign resp_valid = (cnt != '0);

  always_comb begin
    head = '0;
    if (resp_valid) head = rbuf[rp];
  end

  assign resp_pc    = head.pc;
  assign resp_instr = head.instr;
  assign resp_err   = head.err;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: latency, ordering,
// backpressure, error paths, flush, load-port hazard and reset.
module tb_imem_fetch_responder;

  localparam int AW = 12;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_pc;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_pc;
  logic [31:0]   resp_instr;
  logic          resp_err;
  logic          flush;
  logic          ld_en;
  logic [AW-1:0] ld_idx;
  logic [31:0]   ld_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] img [8];

  imem_fetch_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_pc     (req_pc),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pc    (resp_pc),
    .resp_instr (resp_instr),
    .resp_err   (resp_err),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_idx     (ld_idx),
    .ld_data    (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_pc    = pc;
    #1;
    while (!req_ready && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic get_resp(input string tag,
                          input logic [31:0] pc,
                          input logic [31:0] ins,
                          input logic err);
    int n;
    n = 0;
    resp_ready = 1'b1;
    while (!resp_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_v"},   32'(resp_valid), 32'd1);
    chk({tag, "_pc"},  resp_pc, pc);
    chk({tag, "_ins"}, resp_instr, ins);
    chk({tag, "_err"}, 32'(resp_err), 32'(err));
    step();
  endtask

  initial begin
    int acc_n;
    int vcnt;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_pc     = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    ld_en      = 1'b0;
    ld_idx     = '0;
    ld_data    = '0;

    img[0] = 32'h3C01_0001;
    for (int i = 1; i < 8; i++)
      img[i] = 32'hA000_0000 + 32'(i);

    step();
    step();
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_v",   32'(resp_valid), 32'd0);
    chk("rst_pc",  resp_pc, 32'd0);
    chk("rst_ins", resp_instr, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      ld_en   = 1'b1;
      ld_idx  = AW'(i);
      ld_data = img[i];
      step();
    end
    ld_en = 1'b0;
    reset = 1'b0;
    step();

    // 1: single fetch, exact latency
    req_valid = 1'b1;
    req_pc    = 32'h3000;
    #1;
    chk("t1_rdy", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("t1_v0", 32'(resp_valid), 32'd0);
    step();
    chk("t1_v1", 32'(resp_valid), 32'd0);
    step();
    chk("t1_v2",  32'(resp_valid), 32'd1);
    chk("t1_ins", resp_instr, 32'h3C01_0001);
    chk("t1_err", 32'(resp_err), 32'd0);
    chk("t1_pc",  resp_pc, 32'h3000);
    resp_ready = 1'b1;
    step();
    chk("t1_pop", 32'(resp_valid), 32'd0);

    // 2: back-to-back with consumer always ready
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        req_valid = 1'b1;
        req_pc    = 32'h3000 + 32'(4 * c);
        #1;
        chk("t2_rdy", 32'(req_ready), 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (c >= 2 && c <= 4) begin
        chk("t2_v",   32'(resp_valid), 32'd1);
        chk("t2_pc",  resp_pc, 32'h3000 + 32'(4 * (c - 2)));
        chk("t2_ins", resp_instr, img[c-2]);
      end
      if (c == 5)
        chk("t2_end", 32'(resp_valid), 32'd0);
    end

    // 3: backpressure caps outstanding at 4
    resp_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1;
      req_pc    = 32'h3000 + 32'(4 * acc_n);
      #1;
      if (req_ready) acc_n++;
      step();
    end
    req_valid = 1'b0;
    chk("t3_acc", 32'(acc_n), 32'd4);
    chk("t3_rdy", 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++)
      get_resp("t3", 32'h3000 + 32'(4 * i), img[i], 1'b0);
    resp_ready = 1'b0;
    chk("t3_rdy2", 32'(req_ready), 32'd1);
    chk("t3_empty", 32'(resp_valid), 32'd0);

    // 4: error addresses
    send("t4a", 32'h3002);
    get_resp("t4a", 32'h3002, 32'h0, 1'b1);
    send("t4b", 32'h2FFC);
    get_resp("t4b", 32'h2FFC, 32'h0, 1'b1);
    send("t4c", 32'h7000);
    get_resp("t4c", 32'h7000, 32'h0, 1'b1);
    send("t4d", 32'h301C);
    get_resp("t4d", 32'h301C, img[7], 1'b0);
    resp_ready = 1'b0;

    // 5: flush with 3 in flight
    send("t5a", 32'h3000);
    send("t5b", 32'h3004);
    send("t5c", 32'h3008);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_pc    = 32'h300C;
    #1;
    chk("t5_frdy", 32'(req_ready), 32'd0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t5_v",   32'(resp_valid), 32'd0);
    chk("t5_rdy", 32'(req_ready), 32'd1);
    resp_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (resp_valid) vcnt++;
    end
    chk("t5_stale", 32'(vcnt), 32'd0);
    send("t5d", 32'h3010);
    get_resp("t5d", 32'h3010, img[4], 1'b0);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid) vcnt++;
    end
    chk("t5_only", 32'(vcnt), 32'd0);
    resp_ready = 1'b0;

    // 6: same-edge load returns old word
    ld_en   = 1'b1;
    ld_idx  = AW'(1);
    ld_data = 32'hDEAD_BEEF;
    send("t6a", 32'h3004);
    ld_en = 1'b0;
    get_resp("t6a", 32'h3004, img[1], 1'b0);
    send("t6b", 32'h3004);
    get_resp("t6b", 32'h3004, 32'hDEAD_BEEF, 1'b0);
    resp_ready = 1'b0;

    // 6b: reset with two in flight
    send("t6c", 32'h3008);
    send("t6d", 32'h300C);
    reset = 1'b1;
    #1;
    chk("t6_rrdy", 32'(req_ready), 32'd0);
    step();
    chk("t6_rv", 32'(resp_valid), 32'd0);
    reset      = 1'b0;
    resp_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_valid) vcnt++;
    end
    chk("t6_stale", 32'(vcnt), 32'd0);
    chk("t6_pc0",   resp_pc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
